// File: rtl/resp_line_parser.sv
// resp_line_parser: streams "RESP:<hex>\n" lines inside an armed window into a value/valid
// or error pulse; forwards bytes as commands otherwise. Define RESP_CRLF_EN to accept "\r\n".
module resp_line_parser #(
  parameter int unsigned WINDOW_CYCLES = 60_000_000,
  parameter int unsigned NUM_DIGITS    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  input  logic                    arm,
  output logic [4*NUM_DIGITS-1:0] resp_value,
  output logic                    resp_valid,
  output logic                    resp_err,
  output logic [1:0]              err_code,
  output logic [7:0]              cmd_data,
  output logic                    cmd_valid,
  output logic                    busy
);

  localparam int unsigned   VW       = 4 * NUM_DIGITS;
  localparam int unsigned   CW       = $clog2(WINDOW_CYCLES);
  localparam int unsigned   DW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WINDOW_CYCLES - 1);
  localparam logic [DW-1:0] DIG_LAST = DW'(NUM_DIGITS - 1);

  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_LF = 8'h0A;
`ifdef RESP_CRLF_EN
  localparam logic [7:0] CH_CR = 8'h0D;
`endif

  localparam logic [1:0] ERR_EOL     = 2'b00;
  localparam logic [1:0] ERR_PREFIX  = 2'b01;
  localparam logic [1:0] ERR_HEX     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_WAIT_R, S_PREFIX, S_HEX, S_EOL, S_EOL_LF} state_t;

  // Expected byte at prefix index 1..4 of "RESP:" ('R' is index 0, matched in WAIT_R).
  function automatic logic [7:0] prefix_char(input logic [2:0] idx);
    case (idx)
      3'd1:    return 8'h45;
      3'd2:    return 8'h53;
      3'd3:    return 8'h50;
      default: return 8'h3A;
    endcase
  endfunction

  // Returns {is_hex, nibble}.
  function automatic logic [4:0] hex_nib(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39) return {1'b1, b[3:0]};
    if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) return {1'b1, b[3:0] + 4'd9};
    return 5'd0;
  endfunction

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    pidx, pidx_d;
  logic [DW-1:0] didx, didx_d;
  logic [VW-1:0] shadow, shadow_d;
  logic          done, err_ev, cmd_ev, timeout, fwd_ok;
  logic [1:0]    err_code_ev;
  logic [4:0]    hex;

  logic [VW-1:0] resp_value_d;
  logic          resp_valid_d, resp_err_d, cmd_valid_d;
  logic [1:0]    err_code_d;
  logic [7:0]    cmd_data_d;

  assign timeout = (state != S_IDLE) && (cnt == CNT_LAST);
  assign hex     = hex_nib(rx_data);

`ifdef RESP_CRLF_EN
  assign fwd_ok = (rx_data != CH_CR) && (rx_data != CH_LF);
`else
  assign fwd_ok = 1'b1;
`endif

  // NOTE: non-blocking assignments for all registered state, so every flop samples pre-edge values.
  // NOTE: the shadow register is reset like any other flop; it is a single word, not a memory array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      pidx   <= '0;
      didx   <= '0;
      shadow <= '0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      pidx   <= pidx_d;
      didx   <= didx_d;
      shadow <= shadow_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    pidx_d      = pidx;
    didx_d      = didx;
    shadow_d    = shadow;
    done        = 1'b0;
    err_ev      = 1'b0;
    err_code_ev = ERR_EOL;
    cmd_ev      = 1'b0;

    if (arm) begin
      // Arm wins over everything; a same-cycle byte is the first byte of the new window.
      state_d  = S_WAIT_R;
      cnt_d    = '0;
      pidx_d   = '0;
      didx_d   = '0;
      shadow_d = '0;
      if (rx_valid && rx_data == CH_R) begin
        state_d = S_PREFIX;
        pidx_d  = 3'd1;
      end
    end else if (state == S_IDLE) begin
      cmd_ev = rx_valid && fwd_ok;
    end else begin
      cnt_d = cnt + 1'b1;
      if (rx_valid) begin
        case (state)
          S_WAIT_R: if (rx_data == CH_R) begin
            state_d = S_PREFIX;
            pidx_d  = 3'd1;
          end
          S_PREFIX: if (rx_data != prefix_char(pidx)) begin
            state_d     = S_IDLE;
            err_ev      = 1'b1;
            err_code_ev = ERR_PREFIX;
          end else if (pidx == 3'd4) begin
            state_d = S_HEX;
            didx_d  = '0;
          end else begin
            pidx_d = pidx + 3'd1;
          end
          S_HEX: if (!hex[4]) begin
            state_d     = S_IDLE;
            err_ev      = 1'b1;
            err_code_ev = ERR_HEX;
          end else begin
            shadow_d = (shadow << 4) | VW'(hex[3:0]);
            if (didx == DIG_LAST) state_d = S_EOL;
            else                  didx_d  = didx + 1'b1;
          end
          S_EOL: if (rx_data == CH_LF) begin
            state_d = S_IDLE;
            done    = 1'b1;
          end
`ifdef RESP_CRLF_EN
          else if (rx_data == CH_CR) begin
            state_d = S_EOL_LF;
          end
`endif
          else begin
            state_d     = S_IDLE;
            err_ev      = 1'b1;
            err_code_ev = ERR_EOL;
          end
          S_EOL_LF: if (rx_data == CH_LF) begin
            state_d = S_IDLE;
            done    = 1'b1;
          end else begin
            state_d     = S_IDLE;
            err_ev      = 1'b1;
            err_code_ev = ERR_EOL;
          end
          default: ;
        endcase
      end
      // Timeout discards any same-cycle byte except the one completing the line.
      if (timeout && !done) begin
        state_d     = S_IDLE;
        err_ev      = 1'b1;
        err_code_ev = ERR_TIMEOUT;
      end
      if (state_d == S_IDLE) cnt_d = '0;
    end
  end

  always_comb begin
    resp_valid_d = done;
    resp_err_d   = err_ev;
    err_code_d   = err_ev ? err_code_ev : err_code;
    resp_value_d = done ? shadow : resp_value;
    cmd_valid_d  = cmd_ev;
    cmd_data_d   = cmd_ev ? rx_data : cmd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_value <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      err_code   <= 2'b00;
      cmd_data   <= 8'h00;
      cmd_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      resp_value <= resp_value_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      err_code   <= err_code_d;
      cmd_data   <= cmd_data_d;
      cmd_valid  <= cmd_valid_d;
      busy       <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_resp_line_parser.sv
// Scoreboard bench for resp_line_parser: directed lines push expected events, a negedge
// monitor pops and compares each resp_valid / resp_err / cmd_valid pulse.
module tb_resp_line_parser;

  localparam int unsigned WIN = 100;
  localparam int unsigned ND  = 4;

  typedef enum logic [1:0] {EV_VALID, EV_ERR, EV_CMD} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [15:0] value;
    logic [1:0]  code;
    logic [7:0]  data;
    int          cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        arm;
  logic [15:0] resp_value;
  logic        resp_valid;
  logic        resp_err;
  logic [1:0]  err_code;
  logic [7:0]  cmd_data;
  logic        cmd_valid;
  logic        busy;

  ev_t         sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [15:0] last_value = 16'h0;
  logic [1:0]  last_code  = 2'b00;

  resp_line_parser #(.WINDOW_CYCLES(WIN), .NUM_DIGITS(ND)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .arm(arm),
    .resp_value(resp_value), .resp_valid(resp_valid), .resp_err(resp_err),
    .err_code(err_code), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic fwd(input logic [7:0] c);
`ifdef RESP_CRLF_EN
    return (c != 8'h0D) && (c != 8'h0A);
`else
    return (c == c);
`endif
  endfunction

  task automatic push_valid(input logic [15:0] v, input int c);
    sb.push_back('{EV_VALID, v, last_code, 8'h00, c});
    last_value = v;
  endtask

  task automatic push_err(input logic [1:0] code, input int c);
    sb.push_back('{EV_ERR, last_value, code, 8'h00, c});
    last_code = code;
  endtask

  task automatic push_cmd(input logic [7:0] d, input int c);
    sb.push_back('{EV_CMD, last_value, last_code, d, c});
  endtask

  task automatic expect_cmd_str(input string s);
    for (int i = 0; i < s.len(); i++) if (fwd(s[i])) push_cmd(s[i], -1);
  endtask

  // One clock of stimulus; returns #1 after the sampling edge, cyc = that edge.
  task automatic tick(input logic a, input logic v, input logic [7:0] d);
    arm = a; rx_valid = v; rx_data = d;
    @(posedge clk); #1;
    arm = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) tick(1'b0, 1'b1, s[i]);
  endtask

  task automatic idle_until(input int n);
    while (cyc < n) tick(1'b0, 1'b0, 8'h00);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && (resp_valid || resp_err || cmd_valid)) begin
      ev_t      e;
      ev_kind_t k;
      k = resp_valid ? EV_VALID : (resp_err ? EV_ERR : EV_CMD);
      check("valid_err_exclusive", 32'(resp_valid & resp_err), 32'd0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: got kind %0d with nothing expected (cycle %0d)", k, cyc);
      end else begin
        e = sb.pop_front();
        check("event_kind", 32'(k), 32'(e.kind));
        check("resp_value", 32'(resp_value), 32'(e.value));
        check("err_code", 32'(err_code), 32'(e.code));
        if (e.kind == EV_CMD) begin
          check("cmd_data", 32'(cmd_data), 32'(e.data));
          check("cmd_not_busy", 32'(busy), 32'd0);
        end else begin
          check("busy_fallen", 32'(busy), 32'd0);
        end
        if (e.cyc >= 0) check("event_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a, a2;
    rst_n = 1'b0; arm = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    #12;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err",   32'(resp_err),   32'd0);
    check("rst_cmd_valid",  32'(cmd_valid),  32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_value",      32'(resp_value), 32'd0);
    check("rst_code",       32'(err_code),   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1'b0, 1'b0, 8'h00);

    // Upper-case line.
    tick(1'b1, 1'b0, 8'h00);
    check("busy_after_arm", 32'(busy), 32'd1);
    send("RESP:1A2F\n");
    push_valid(16'h1A2F, cyc);
    idle_until(cyc + 3);

    // Lower-case line, then a command byte.
    tick(1'b1, 1'b0, 8'h00);
    send("RESP:1a2f\n");
    push_valid(16'h1A2F, cyc);
    send("Y");
    push_cmd(8'h59, cyc);
    idle_until(cyc + 3);

    // Prefix mismatch; the rest of the line is forwarded as commands.
    tick(1'b1, 1'b0, 8'h00);
    send("RESQ");
    push_err(2'b01, cyc);
    expect_cmd_str("RESP:0001\n");
    send("RESP:0001\n");
    idle_until(cyc + 3);

    // Bad hex digit.
    tick(1'b1, 1'b0, 8'h00);
    send("RESP:12G");
    push_err(2'b10, cyc);
    expect_cmd_str("4\n");
    send("4\n");
    idle_until(cyc + 3);

    // Bad end of line.
    tick(1'b1, 1'b0, 8'h00);
    send("RESP:1234X");
    push_err(2'b00, cyc);
    idle_until(cyc + 3);

    // Arm together with 'R'; noise before 'R' is dropped.
    tick(1'b1, 1'b1, 8'h52);
    send("ESP:00FF\n");
    push_valid(16'h00FF, cyc);
    tick(1'b1, 1'b0, 8'h00);
    send("zzRESP:ABCD\n");
    push_valid(16'hABCD, cyc);
    idle_until(cyc + 3);

    // Timeout exactly WIN cycles after arm.
    tick(1'b1, 1'b0, 8'h00);
    a = cyc;
    send("RESP:12");
    push_err(2'b11, a + WIN);
    idle_until(a + WIN + 5);

    // Re-arm mid-line restarts the window without an error pulse.
    tick(1'b1, 1'b0, 8'h00);
    a = cyc;
    send("RESP:12");
    idle_until(a + 49);
    tick(1'b1, 1'b0, 8'h00);
    a2 = cyc;
    check("rearm_busy", 32'(busy), 32'd1);
    push_err(2'b11, a2 + WIN);
    idle_until(a2 + WIN + 5);

    // Completing '\n' on the timeout cycle: valid wins.
    tick(1'b1, 1'b0, 8'h00);
    a = cyc;
    send("RESP:BEEF");
    idle_until(a + WIN - 1);
    tick(1'b0, 1'b1, 8'h0A);
    push_valid(16'hBEEF, a + WIN);
    idle_until(cyc + 3);

    // Non-completing byte on the timeout cycle: timeout wins, byte discarded.
    tick(1'b1, 1'b0, 8'h00);
    a = cyc;
    send("RESP:BEE");
    idle_until(a + WIN - 1);
    push_err(2'b11, a + WIN);
    tick(1'b0, 1'b1, 8'h46);
    idle_until(cyc + 3);

    // CR LF ending.
    tick(1'b1, 1'b0, 8'h00);
`ifdef RESP_CRLF_EN
    send("RESP:1234\015\n");
    push_valid(16'h1234, cyc);
    send("\015\nN");
    push_cmd(8'h4E, cyc);
`else
    send("RESP:1234\015");
    push_err(2'b00, cyc);
    expect_cmd_str("\nN");
    send("\nN");
`endif
    idle_until(cyc + 3);

    // Reset mid-line: back to idle, nothing emitted afterwards.
    tick(1'b1, 1'b0, 8'h00);
    send("RESP:1");
    #2 rst_n = 1'b0;
    #1 check("rst_mid_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_value = 16'h0;
    last_code  = 2'b00;
    idle_until(cyc + WIN + 20);
    check("post_rst_busy", 32'(busy), 32'd0);
    send("Y");
    push_cmd(8'h59, cyc);
    idle_until(cyc + 10);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
